rat_intr_ctrl: RTL and testbench
================================

// Module: rat_intr_ctrl
// PURPOSE
//  Interrupt controller that drives the control unit's single `interrupt` input and consumes its interrupt-side outputs.
//  - Collects up to NUM_SRC external request lines, synchronizes them and latches rising edges as pending.
//  - Applies a software mask and the global I flag (mirrors the CU's i_set/i_clr).
//  - Holds a request until the CU acknowledges.
//  - Exposes mask, pending and the serviced-vector registers on the IN/OUT port bus.
// PARAMETERS
//  NUM_SRC     8      number of request sources, 1..8
//  SYNC_STAGES 2      synchronizer flops per source, >=2
//  PORT_MASK   8'h30  port ID: mask register (R/W)
//  PORT_PEND   8'h31  port ID: pending register (R; W1C on OUT)
//  PORT_VEC    8'h32  port ID: index of last acknowledged source (R only)
// PORTS
//  clk          in   1        system clock
//  reset_n      in   1        asynchronous reset, active-low
//  irq_src      in   NUM_SRC  asynchronous request lines, rising-edge sensitive
//  i_set        in   1        CU i_set (SEI/RETIE): set global enable
//  i_clr        in   1        CU i_clr (CLI/RETID/interrupt cycle): clear global enable
//  intr_ack     in   1        CU flg_shad_ld; high exactly in the CU interrupt cycle
//  io_strb      in   1        CU OUT strobe; write qualifier for out_port
//  port_id      in   8        I/O port address
//  out_port     in   8        OUT data
//  in_data      out  8        read data for port_id; 0 when in_hit=0
//  in_hit       out  1        port_id matches one of this block's ports
//  interrupt    out  1        request to CU; registered
//  busy         out  1        servicing in progress, for debug/LED
// BEHAVIOUR
//  Reset (async, reset_n=0), all outputs low:
//   - State IDLE; mask=0, pending=0, vec=0, ien=0, sync chains=0.
//   - Outputs: interrupt=0, busy=0, in_hit=0, in_data=0.
//  Input path:
//   - Each irq_src bit passes SYNC_STAGES flops, then a rising-edge detect (sync & ~prev).
//   - A detected edge sets pending[k] on the next clk.
//  Pending clear:
//   - OUT to PORT_PEND clears bits written 1.
//   - Ack clears the serviced bit.
//   - Set beats clear when both happen in the same cycle.
//  Mask register:
//   - OUT to PORT_MASK loads out_port[NUM_SRC-1:0].
//   - Unused upper bits read 0.
//  Global enable ien:
//   - i_set -> 1; i_clr -> 0.
//   - i_set and i_clr in the same cycle: i_clr wins.
//  req = ien & |(pending & mask).
//  FSM (registered; interrupt = (state==REQ)):
//   - IDLE:    req -> REQ.
//   - REQ:     intr_ack -> ACK. If !req without ack (CLI, mask write or W1C) -> IDLE, and interrupt drops next cycle.
//   - ACK:     one cycle, no outputs asserted; -> SERVICE.
//   - SERVICE: busy=1; i_set -> IDLE.
//  Acknowledge:
//   - On intr_ack in REQ, vec <= lowest index k with pending[k]&mask[k]. Lowest index has fixed highest priority.
//   - pending[k] is cleared in the same cycle.
//   - intr_ack outside REQ is ignored; vec and pending are unchanged.
//  Nesting:
//   - None. Requests arriving in ACK/SERVICE only accumulate in pending.
//   - They are re-requested after RETIE/SEI returns the FSM to IDLE.
//  Read path:
//   - Combinational from port_id: MASK->mask, PEND->pending, VEC->{5'b0,vec}.
//   - Zero-extended to 8 bits.
//  Writes:
//   - Take effect only on cycles with io_strb=1.
//   - OUT to PORT_VEC is ignored.
//  Mid-operation reset:
//   - Any state returns to IDLE asynchronously.
//   - interrupt deasserts immediately; pending edges are lost.
// STRUCTURE
//  Package rat_pkg:
//   - typedef enum {INT_IDLE, INT_REQ, INT_ACK, INT_SERVICE} IntState.
//   - localparams PORT_MASK/PEND/VEC defaults.
//  Sub-module irq_sync_edge:
//   - Parameter SYNC_STAGES.
//   - Ports: clk, reset_n, d (async input), rise (one-cycle pulse).
//   - Instantiated NUM_SRC times by generate.
//  Priority encoder and register file stay inline.
// TESTING
//  1. Basic service: reset; OUT mask=8'h01; pulse i_set; raise irq_src[0].
//     -> interrupt=1 exactly SYNC_STAGES+2 clks later.
//     -> After an intr_ack pulse: interrupt=0, busy=1, pending=0, vec reads 0.
//  2. Priority: mask=8'hFF, ien=1, edges on src 5 and src 2 in the same clk.
//     -> ack gives vec=2, pending=8'h20.
//     -> After i_set: interrupt reasserts, next ack gives vec=5.
//  3. Masking: mask=0, src3 edge.
//     -> pending=8'h08, interrupt stays 0.
//     -> OUT mask=8'h08: interrupt=1 two clks later.
//  4. Withdraw: in REQ, OUT PORT_PEND with 8'hFF.
//     -> interrupt falls next clk, FSM IDLE, vec unchanged.
//     -> Repeat with i_clr instead of the write: same result.
//  5. Collisions:
//     -> W1C of bit 1 in the same clk as a src1 edge: pending[1] stays 1.
//     -> i_set and i_clr together: ien=0.
//  6. Async reset: drop reset_n mid-SERVICE, between clk edges.
//     -> busy/interrupt 0 before the next clk; all registers read 0 after release.

Source files
------------

// File: rtl/rat_pkg.sv
// ---------------------------------------------------------------------------
// rat_pkg
//   Shared types and constants for the RAT interrupt controller.
//   - IntState : interrupt FSM states
//   - PORT_*_DEFAULT : default I/O port IDs of the controller registers
//   - VEC_W : width of the serviced-vector register (index of up to 8 sources)
// ---------------------------------------------------------------------------
package rat_pkg;

   typedef enum logic [1:0] {
      INT_IDLE,
      INT_REQ,
      INT_ACK,
      INT_SERVICE
   } IntState;

   localparam logic [7:0] PORT_MASK_DEFAULT = 8'h30;
   localparam logic [7:0] PORT_PEND_DEFAULT = 8'h31;
   localparam logic [7:0] PORT_VEC_DEFAULT  = 8'h32;

   localparam int VEC_W = 3;

endpackage

// File: rtl/irq_sync_edge.sv
// ---------------------------------------------------------------------------
// irq_sync_edge
//   Synchronizes one asynchronous request line and flags its rising edge.
//   Ports:
//     clk     : system clock
//     reset_n : asynchronous reset, active-low
//     d       : asynchronous request input
//     rise    : one-cycle pulse after a synchronized 0->1 transition
// ---------------------------------------------------------------------------
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so each stage captures its neighbour's old value;
         // blocking assignments here would collapse the chain into one flop.
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/rat_intr_ctrl.sv
// ---------------------------------------------------------------------------
// rat_intr_ctrl
//   Interrupt controller in front of the RAT control unit. Latches rising
//   edges of NUM_SRC request lines as pending, qualifies them with a software
//   mask and the global I flag, and holds `interrupt` until the CU acks.
//   Ports:
//     clk, reset_n       : clock, asynchronous active-low reset
//     irq_src            : asynchronous request lines (rising-edge sensitive)
//     i_set / i_clr      : CU global-enable set / clear (clear wins)
//     intr_ack           : CU interrupt-cycle acknowledge
//     io_strb, port_id,
//     out_port           : CU OUT bus (write when io_strb=1)
//     in_data, in_hit    : read data / address match for port_id
//     interrupt          : registered request to the CU
//     busy               : high while an interrupt is being serviced
// ---------------------------------------------------------------------------
module rat_intr_ctrl
   import rat_pkg::*;
#(
   parameter int         NUM_SRC     = 8,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] PORT_MASK   = PORT_MASK_DEFAULT,
   parameter logic [7:0] PORT_PEND   = PORT_PEND_DEFAULT,
   parameter logic [7:0] PORT_VEC    = PORT_VEC_DEFAULT
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic               i_set,
   input  logic               i_clr,
   input  logic               intr_ack,
   input  logic               io_strb,
   input  logic [7:0]         port_id,
   input  logic [7:0]         out_port,
   output logic [7:0]         in_data,
   output logic               in_hit,
   output logic               interrupt,
   output logic               busy
);

   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] mask;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] active;
   logic [NUM_SRC-1:0] w1c;
   logic [NUM_SRC-1:0] ack_clr;
   logic [VEC_W-1:0]   vec;
   logic [VEC_W-1:0]   ack_idx;
   logic               ien;
   logic               req;
   logic               ack_fire;
   logic               wr_mask;
   logic               wr_pend;
   logic [7:0]         mask_rd;
   logic [7:0]         pend_rd;
   IntState            state;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      irq_sync_edge #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
         .clk     (clk),
         .reset_n (reset_n),
         .d       (irq_src[g]),
         .rise    (rise[g])
      );
   end

   assign wr_mask  = io_strb && (port_id == PORT_MASK);
   assign wr_pend  = io_strb && (port_id == PORT_PEND);
   assign w1c      = wr_pend ? out_port[NUM_SRC-1:0] : {NUM_SRC{1'b0}};
   assign active   = pending & mask;
   assign req      = ien & (|active);
   // Acks are only honoured while a request is actually on the wire.
   assign ack_fire = intr_ack && (state == INT_REQ);

   // Fixed priority: scanning downward lets the lowest active index win.
   always_comb begin
      // NOTE: defaults first so every path assigns every output; a missing
      // default in always_comb infers a latch.
      ack_idx = '0;
      ack_clr = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         if (active[k]) begin
            ack_idx    = VEC_W'(k);
            ack_clr    = '0;
            ack_clr[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask    <= '0;
         pending <= '0;
         vec     <= '0;
         ien     <= 1'b0;
      end else begin
         if (wr_mask) begin
            mask <= out_port[NUM_SRC-1:0];
         end
         // New edges are ORed in last so a set beats a same-cycle clear.
         pending <= (pending & ~w1c & ~(ack_fire ? ack_clr : {NUM_SRC{1'b0}})) | rise;
         if (ack_fire && (|active)) begin
            vec <= ack_idx;
         end
         if (i_clr) begin
            ien <= 1'b0;
         end else if (i_set) begin
            ien <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= INT_IDLE;
         interrupt <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            INT_IDLE: begin
               if (req) begin
                  state     <= INT_REQ;
                  interrupt <= 1'b1;
               end
            end
            INT_REQ: begin
               if (intr_ack) begin
                  state     <= INT_ACK;
                  interrupt <= 1'b0;
               end else if (!req) begin
                  // Request withdrawn by CLI, mask write or W1C.
                  state     <= INT_IDLE;
                  interrupt <= 1'b0;
               end
            end
            INT_ACK: begin
               state <= INT_SERVICE;
               busy  <= 1'b1;
            end
            INT_SERVICE: begin
               if (i_set) begin
                  state <= INT_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state     <= INT_IDLE;
               interrupt <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // Read mux; held inactive during reset so the bus sees no hit.
   always_comb begin
      mask_rd                = '0;
      pend_rd                = '0;
      mask_rd[NUM_SRC-1:0]   = mask;
      pend_rd[NUM_SRC-1:0]   = pending;
      in_hit                 = 1'b0;
      in_data                = '0;
      if (reset_n) begin
         if (port_id == PORT_MASK) begin
            in_hit  = 1'b1;
            in_data = mask_rd;
         end else if (port_id == PORT_PEND) begin
            in_hit  = 1'b1;
            in_data = pend_rd;
         end else if (port_id == PORT_VEC) begin
            in_hit  = 1'b1;
            in_data = {{(8 - VEC_W){1'b0}}, vec};
         end
      end
   end

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rat_intr_ctrl
//   Self-checking bench for rat_intr_ctrl: directed scenarios with literal
//   expectations plus a behavioural model compared on every falling edge.
// ---------------------------------------------------------------------------
module tb_rat_intr_ctrl;

   localparam int         NSRC   = 8;
   localparam int         S      = 2;
   localparam logic [7:0] P_MASK = 8'h30;
   localparam logic [7:0] P_PEND = 8'h31;
   localparam logic [7:0] P_VEC  = 8'h32;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [NSRC-1:0] irq_src;
   logic            i_set;
   logic            i_clr;
   logic            intr_ack;
   logic            io_strb;
   logic [7:0]      port_id;
   logic [7:0]      out_port;
   logic [7:0]      in_data;
   logic            in_hit;
   logic            interrupt;
   logic            busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   rat_intr_ctrl #(
      .NUM_SRC     (NSRC),
      .SYNC_STAGES (S),
      .PORT_MASK   (P_MASK),
      .PORT_PEND   (P_PEND),
      .PORT_VEC    (P_VEC)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .irq_src   (irq_src),
      .i_set     (i_set),
      .i_clr     (i_clr),
      .intr_ack  (intr_ack),
      .io_strb   (io_strb),
      .port_id   (port_id),
      .out_port  (out_port),
      .in_data   (in_data),
      .in_hit    (in_hit),
      .interrupt (interrupt),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {M_IDLE, M_REQ, M_ACK, M_SVC} phase_t;

   phase_t     m_phase;
   logic [7:0] m_mask;
   logic [7:0] m_pend;
   logic [2:0] m_vec;
   logic       m_ien;
   logic [7:0] hist [0:S];   // hist[0] = irq_src sampled at the previous edge
   logic [7:0] m_edges;
   logic [7:0] m_w1c;
   logic [7:0] m_ack_bit;
   logic       m_req;
   logic       m_took_ack;
   int         m_pick;

   function automatic int lowest(input logic [7:0] v);
      for (int k = 0; k < 8; k++) begin
         if (v[k]) return k;
      end
      return -1;
   endfunction

   function automatic logic [7:0] model_read(input logic [7:0] pid);
      if (pid == P_MASK) return m_mask;
      if (pid == P_PEND) return m_pend;
      if (pid == P_VEC)  return {5'b0, m_vec};
      return 8'h00;
   endfunction

   // A line seen high S samples ago and low S+1 samples ago lands in pending now.
   assign m_edges    = hist[S-1] & ~hist[S];
   assign m_w1c      = (io_strb && port_id == P_PEND) ? out_port : 8'h00;
   assign m_req      = m_ien && ((m_pend & m_mask) != 8'h00);
   assign m_pick     = lowest(m_pend & m_mask);
   assign m_took_ack = (m_phase == M_REQ) && intr_ack;
   assign m_ack_bit  = (m_took_ack && m_pick >= 0) ? (8'h01 << m_pick) : 8'h00;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_phase <= M_IDLE;
         m_mask  <= 8'h00;
         m_pend  <= 8'h00;
         m_vec   <= 3'd0;
         m_ien   <= 1'b0;
         for (int i = 0; i <= S; i++) hist[i] <= 8'h00;
      end else begin
         hist[0] <= irq_src;
         for (int i = 1; i <= S; i++) hist[i] <= hist[i-1];
         if (io_strb && port_id == P_MASK) m_mask <= out_port;
         m_pend <= (m_pend & ~m_w1c & ~m_ack_bit) | m_edges;
         if (m_took_ack && m_pick >= 0) m_vec <= 3'(m_pick);
         m_ien <= i_clr ? 1'b0 : (i_set ? 1'b1 : m_ien);
         case (m_phase)
            M_IDLE:  if (m_req) m_phase <= M_REQ;
            M_REQ:   if (intr_ack) m_phase <= M_ACK; else if (!m_req) m_phase <= M_IDLE;
            M_ACK:   m_phase <= M_SVC;
            default: if (i_set) m_phase <= M_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      check("cmp_interrupt", interrupt, (reset_n && m_phase == M_REQ));
      check("cmp_busy", busy, (reset_n && m_phase == M_SVC));
      check("cmp_in_hit", in_hit,
            (reset_n && (port_id == P_MASK || port_id == P_PEND || port_id == P_VEC)));
      check("cmp_in_data", in_data, reset_n ? model_read(port_id) : 8'h00);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic out_write(input logic [7:0] pid, input logic [7:0] data);
      port_id  = pid;
      out_port = data;
      io_strb  = 1'b1;
      tick();
      io_strb  = 1'b0;
      port_id  = 8'h00;
      out_port = 8'h00;
   endtask

   task automatic read_check(input string name, input logic [7:0] pid, input logic [7:0] exp);
      port_id = pid;
      #1;
      check(name, in_data, exp);
      check({name, "_hit"}, in_hit, 1'b1);
      port_id = 8'h00;
   endtask

   task automatic pulse_set();
      i_set = 1'b1;
      tick();
      i_set = 1'b0;
   endtask

   task automatic pulse_clr();
      i_clr = 1'b1;
      tick();
      i_clr = 1'b0;
   endtask

   task automatic pulse_ack();
      intr_ack = 1'b1;
      tick();
      intr_ack = 1'b0;
   endtask

   task automatic wait_intr(input string name);
      int n = 0;
      while (!interrupt && n < 20) begin
         tick();
         n++;
      end
      check(name, interrupt, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected end before 200000");
      $fatal(1);
   end

   // ---------------- directed scenarios ----------------
   initial begin
      reset_n  = 1'b1;
      irq_src  = '0;
      i_set    = 1'b0;
      i_clr    = 1'b0;
      intr_ack = 1'b0;
      io_strb  = 1'b0;
      port_id  = P_MASK;
      out_port = 8'h00;
      #1 reset_n = 1'b0;
      #2;
      check("rst_in_hit", in_hit, 1'b0);
      check("rst_in_data", in_data, 8'h00);
      check("rst_interrupt", interrupt, 1'b0);
      check("rst_busy", busy, 1'b0);
      port_id = 8'h00;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      read_check("rst_mask", P_MASK, 8'h00);
      read_check("rst_pend", P_PEND, 8'h00);
      read_check("rst_vec", P_VEC, 8'h00);

      // 1. basic service and latency
      out_write(P_MASK, 8'h01);
      pulse_set();
      irq_src[0] = 1'b1;
      for (int k = 1; k <= S + 2; k++) begin
         tick();
         check($sformatf("t1_latency_%0d", k), interrupt, (k == S + 2));
      end
      pulse_ack();
      tick();
      check("t1_intr_after_ack", interrupt, 1'b0);
      check("t1_busy", busy, 1'b1);
      read_check("t1_pend", P_PEND, 8'h00);
      read_check("t1_vec", P_VEC, 8'h00);
      irq_src[0] = 1'b0;
      pulse_ack();
      check("t1_busy_hold", busy, 1'b1);
      pulse_set();
      check("t1_busy_done", busy, 1'b0);
      pulse_ack();
      read_check("t1_stray_ack_vec", P_VEC, 8'h00);

      // 2. priority
      out_write(P_MASK, 8'hFF);
      irq_src = 8'h24;
      wait_intr("t2_req1");
      pulse_ack();
      read_check("t2_vec1", P_VEC, 8'h02);
      read_check("t2_pend1", P_PEND, 8'h20);
      tick();
      pulse_set();
      wait_intr("t2_req2");
      pulse_ack();
      read_check("t2_vec2", P_VEC, 8'h05);
      read_check("t2_pend2", P_PEND, 8'h00);
      tick();
      pulse_set();
      irq_src = '0;

      // 3. masking
      out_write(P_MASK, 8'h00);
      irq_src[3] = 1'b1;
      repeat (5) tick();
      read_check("t3_pend", P_PEND, 8'h08);
      check("t3_masked", interrupt, 1'b0);
      out_write(P_MASK, 8'h08);
      check("t3_write_edge", interrupt, 1'b0);
      tick();
      check("t3_unmasked", interrupt, 1'b1);

      // 4. withdraw by W1C, then by CLI
      out_write(P_PEND, 8'hFF);
      tick();
      check("t4_w1c_drop", interrupt, 1'b0);
      check("t4_w1c_busy", busy, 1'b0);
      read_check("t4_w1c_vec", P_VEC, 8'h05);
      read_check("t4_w1c_pend", P_PEND, 8'h00);
      irq_src[3] = 1'b0;
      repeat (3) tick();
      irq_src[3] = 1'b1;
      wait_intr("t4_req2");
      pulse_clr();
      tick();
      check("t4_cli_drop", interrupt, 1'b0);
      read_check("t4_cli_vec", P_VEC, 8'h05);
      read_check("t4_cli_pend", P_PEND, 8'h08);
      pulse_set();
      wait_intr("t4_req3");
      pulse_ack();
      read_check("t4_vec3", P_VEC, 8'h03);
      tick();
      pulse_set();
      irq_src[3] = 1'b0;

      // 5. collisions
      irq_src[1] = 1'b1;
      repeat (4) tick();
      read_check("t5_pend_pre", P_PEND, 8'h02);
      irq_src[1] = 1'b0;
      repeat (3) tick();
      irq_src[1] = 1'b1;
      tick();
      tick();
      out_write(P_PEND, 8'h02);
      read_check("t5_set_beats_clear", P_PEND, 8'h02);
      i_set = 1'b1;
      i_clr = 1'b1;
      tick();
      i_set = 1'b0;
      i_clr = 1'b0;
      out_write(P_MASK, 8'h02);
      repeat (3) tick();
      check("t5_clr_wins", interrupt, 1'b0);
      pulse_set();
      tick();
      check("t5_ien_set", interrupt, 1'b1);
      out_write(P_PEND, 8'h02);
      tick();
      check("t5_w1c_drop", interrupt, 1'b0);
      read_check("t5_pend_clear", P_PEND, 8'h00);
      irq_src[1] = 1'b0;

      // 6. async reset mid-SERVICE
      repeat (3) tick();
      irq_src[1] = 1'b1;
      wait_intr("t6_req");
      pulse_ack();
      tick();
      check("t6_busy_pre", busy, 1'b1);
      #2;
      reset_n = 1'b0;
      irq_src = '0;
      #1;
      check("t6_busy_async", busy, 1'b0);
      check("t6_intr_async", interrupt, 1'b0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      read_check("t6_mask", P_MASK, 8'h00);
      read_check("t6_pend", P_PEND, 8'h00);
      read_check("t6_vec", P_VEC, 8'h00);
      repeat (2) tick();
      check("t6_idle_busy", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
